// File: rtl/btn_pkg.sv
// Shared definitions for the debounced-button event path: channel FSM states
// and the mapping of button channels to bit positions.
package btn_pkg;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    PRESSED,
    HELD
  } btn_state_e;

  localparam int N_BTN_DEFAULT = 4;

  localparam int BTN_HS      = 0;
  localparam int BTN_VS      = 1;
  localparam int BTN_DF_UART = 2;
  localparam int BTN_DF_VGA  = 3;

endpackage

// File: rtl/btn_event_chan.sv
// One button channel: turns a clean level into press / short / long / repeat /
// release pulses plus a press-toggled level, all registered.
module btn_event_chan
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic toggle
);

  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_C   = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARM;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        // A button held through reset must be released before it can fire.
        ARM: begin
          if (!level) state <= IDLE;
        end
        IDLE: begin
          if (level) begin
            state       <= PRESSED;
            cnt         <= CNT_W'(1);
            press_pulse <= 1'b1;
            toggle      <= ~toggle;
          end
        end
        // cnt equals the number of edges since the press edge, so the long
        // threshold lands exactly LONG_CYCLES edges after the press; a release
        // on that same edge takes priority and still counts as short.
        PRESSED: begin
          if (!level) begin
            state         <= IDLE;
            cnt           <= '0;
            short_pulse   <= 1'b1;
            release_pulse <= 1'b1;
          end else if (cnt == LONG_C) begin
            state      <= HELD;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        HELD: begin
          if (!level) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end else if (sat_inc(cnt) == REP_C) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= ARM;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_decoder.sv
// Bank of independent button channels converting debounced levels into
// single-cycle control events for the UART and VGA control registers.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int N_BTN         = N_BTN_DEFAULT,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] short_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] toggle
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_event_chan #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .level        (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .short_pulse  (short_pulse[g]),
      .long_pulse   (long_pulse[g]),
      .repeat_pulse (repeat_pulse[g]),
      .release_pulse(release_pulse[g]),
      .toggle       (toggle[g])
    );
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: directed scenarios and random holds, checked
// every cycle against a hold-age reference model.
module tb_btn_event_decoder;
  import btn_pkg::*;

  localparam int NB = 4;
  localparam int LC = 8;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, toggle;

  always #5 clk = ~clk;

  btn_event_decoder #(
    .N_BTN(NB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .press_pulse(press_pulse), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .release_pulse(release_pulse), .toggle(toggle)
  );

  int total = 0;
  int bad = 0;

  // Reference model: a channel is blocked after reset until it sees a low
  // sample; otherwise an active press is described only by its age in edges.
  bit            m_block[NB];
  bit            m_active[NB];
  int            m_age[NB];
  logic [NB-1:0] e_press, e_short, e_long, e_rep, e_rel, e_tog;

  logic [6*NB-1:0] obs, expv;
  assign obs  = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, toggle};
  assign expv = {e_press, e_short, e_long, e_rep, e_rel, e_tog};

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_block[i] = 1'b1; m_active[i] = 1'b0; m_age[i] = 0;
    end
    e_press = '0; e_short = '0; e_long = '0; e_rep = '0; e_rel = '0; e_tog = '0;
  endtask

  task automatic model_edge(input logic [NB-1:0] lvl);
    e_press = '0; e_short = '0; e_long = '0; e_rep = '0; e_rel = '0;
    for (int i = 0; i < NB; i++) begin
      if (m_block[i]) begin
        if (!lvl[i]) m_block[i] = 1'b0;
      end else if (!m_active[i]) begin
        if (lvl[i]) begin
          m_active[i] = 1'b1; m_age[i] = 0;
          e_press[i] = 1'b1; e_tog[i] = ~e_tog[i];
        end
      end else begin
        m_age[i] = m_age[i] + 1;
        if (!lvl[i]) begin
          e_rel[i]   = 1'b1;
          e_short[i] = (m_age[i] <= LC);
          m_active[i] = 1'b0;
        end else if (m_age[i] == LC) begin
          e_long[i] = 1'b1;
        end else if (m_age[i] > LC && ((m_age[i] - LC) % RC) == 0) begin
          e_rep[i] = 1'b1;
        end
      end
    end
  endtask

  // Drive one level for one edge, advance the model, sample 1 time unit later.
  task automatic cycle(input logic [NB-1:0] lvl);
    @(negedge clk);
    btn_level = lvl;
    @(posedge clk);
    model_edge(lvl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_level = 4'b0001;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0001);
      total++;
      if (obs !== expv || press_pulse[BTN_HS] !== 1'b0) begin
        bad++; $display("FAIL arm_hold k=%0d got=%h want=%h", k, obs, expv);
      end
    end
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000);
      total++;
      if (obs !== expv || obs !== '0) begin
        bad++; $display("FAIL arm_release k=%0d got=%h want=%h", k, obs, expv);
      end
    end
    cycle(4'b0001);
    total++;
    if (obs !== expv || press_pulse[BTN_HS] !== 1'b1 || toggle[BTN_HS] !== 1'b1) begin
      bad++; $display("FAIL first_press got=%h want=%h", obs, expv);
    end
    cycle(4'b0000);
    cycle(4'b0000);
  endtask

  task automatic test_short();
    logic tog0;
    tog0 = toggle[BTN_VS];
    for (int k = 0; k < 5; k++) begin
      cycle(k < 3 ? 4'b0010 : 4'b0000);
      total++;
      if (obs !== expv
          || press_pulse[BTN_VS]   !== (k == 0)
          || short_pulse[BTN_VS]   !== (k == 3)
          || release_pulse[BTN_VS] !== (k == 3)
          || long_pulse[BTN_VS]    !== 1'b0
          || toggle[BTN_VS]        !== ~tog0) begin
        bad++; $display("FAIL short_press k=%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_long_repeat();
    for (int k = 0; k < 22; k++) begin
      cycle(k < 20 ? 4'b0100 : 4'b0000);
      total++;
      if (obs !== expv
          || long_pulse[BTN_DF_UART]    !== (k == 8)
          || repeat_pulse[BTN_DF_UART]  !== (k == 12 || k == 16)
          || release_pulse[BTN_DF_UART] !== (k == 20)
          || short_pulse[BTN_DF_UART]   !== 1'b0) begin
        bad++; $display("FAIL long_repeat k=%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_threshold_release();
    for (int k = 0; k < 10; k++) begin
      cycle(k < 8 ? 4'b1000 : 4'b0000);
      total++;
      if (obs !== expv
          || short_pulse[BTN_DF_VGA]   !== (k == 8)
          || release_pulse[BTN_DF_VGA] !== (k == 8)
          || long_pulse[BTN_DF_VGA]    !== 1'b0) begin
        bad++; $display("FAIL threshold_release k=%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] seq [6];
    seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
    for (int k = 0; k < 6; k++) begin
      cycle(seq[k]);
      total++;
      if (obs !== expv
          || press_pulse   !== (k == 0 ? 4'b1111 : 4'b0000)
          || release_pulse !== (k >= 1 && k <= 4 ? (4'b0001 << (k - 1)) : 4'b0000)) begin
        bad++; $display("FAIL simultaneous k=%0d got=%h want=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int k = 0; k < 11; k++) cycle(4'b0001);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL async_reset got=%h want=0", obs);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(4'b0001);
      total++;
      if (obs !== expv || obs !== '0) begin
        bad++; $display("FAIL rearm_hold k=%0d got=%h want=%h", k, obs, expv);
      end
    end
    for (int p = 0; p < 3; p++) begin
      cycle(4'b0000);
      cycle(4'b0000);
      cycle(4'b0001);
      total++;
      if (obs !== expv || press_pulse[BTN_HS] !== 1'b1 || toggle[BTN_HS] !== ((p % 2) == 0)) begin
        bad++; $display("FAIL toggle_seq p=%0d got=%h want=%h", p, obs, expv);
      end
    end
    cycle(4'b0000);
    cycle(4'b0000);
  endtask

  task automatic test_random();
    logic [NB-1:0] lvl;
    lvl = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 7) == 0) lvl[i] = ~lvl[i];
      cycle(lvl);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL random k=%0d lvl=%b got=%h want=%h", k, lvl, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long_repeat();
    test_threshold_release();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
